data_conv_punct_enc: RTL and testbench

Parametrised rate-1/2 convolutional encoder with 802.11a-style puncturing to rates 2/3 and 3/4, plus automatic tail-bit flush. Uses frame-based input and valid/ready handshakes on both sides. Output is a serial bit stream, so the block throttles its input whenever puncturing leaves two bits pending. Sits between the scrambler and the interleaver in the OFDM data path, clocked at 60 MHz.

---
 rtl/data_conv_punct_enc.sv | 98 +++++++++
 tb/tb_data_conv_punct_enc.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/data_conv_punct_enc.sv
// data_conv_punct_enc: rate-1/2 convolutional encoder with 2/3, 3/4 puncturing, tail flush and serial output
module data_conv_punct_enc #(
  parameter int           K       = 7,
  parameter logic [K-1:0] G_A     = 7'o133,
  parameter logic [K-1:0] G_B     = 7'o171,
  parameter bit           TAIL_EN = 1'b1
) (
  input  logic       din_clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_vld,
  input  logic       din_sop,
  input  logic       din_eop,
  output logic       din_rdy,
  input  logic [1:0] rate_sel,
  output logic       dout,
  output logic       dout_vld,
  output logic       dout_eop,
  input  logic       dout_rdy
);
  localparam int TW = $clog2(K);
  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
  state_t        state_q, state_d;
  logic [K-2:0]  sr_q, sr_d;
  logic [1:0]    phase_q, phase_d, rate_q, rate_d, pend_q, pend_d, buf_q, buf_d, beop_q, beop_d;
  logic [TW-1:0] tail_q, tail_d;
  logic          started_q;
  logic          pop, can_load, xfer, tail_go, enc, sop, bit_in, a, b, keep_a, keep_b, last, r23, r34;
  logic [K-2:0]  hist;
  logic [K-1:0]  win;
  logic [1:0]    rate_e, ph, ph_next;
  assign dout_vld = pend_q != 2'd0;
  assign dout     = buf_q[0];
  assign dout_eop = beop_q[0];
  // Handshake, encoder datapath, puncturing, serializer and state sequencing.
  always_comb begin
    pop      = dout_vld & dout_rdy;
    can_load = started_q & ((pend_q == 2'd0) | ((pend_q == 2'd1) & dout_rdy));
    din_rdy  = can_load & (state_q != TAIL);
    xfer     = din_vld & din_rdy;
    tail_go  = (state_q == TAIL) & can_load;
    enc      = xfer | tail_go;
    sop      = xfer & din_sop;
    bit_in   = xfer & din;
    hist     = sop ? '0 : sr_q;
    win      = {bit_in, hist};
    a        = ^(win & G_A);
    b        = ^(win & G_B);
    rate_e   = sop ? rate_sel : rate_q;
    ph       = sop ? 2'd0 : phase_q;
    r23      = rate_e == 2'd1;
    r34      = rate_e == 2'd2;
    keep_a   = !(r34 & (ph == 2'd2));
    keep_b   = !((r23 | r34) & (ph == 2'd1));
    ph_next  = (r23 & (ph == 2'd0)) ? 2'd1 : (r34 & (ph != 2'd2)) ? ph + 2'd1 : 2'd0;
    last     = (xfer & din_eop & !TAIL_EN) | (tail_go & (tail_q == TW'(K - 2)));
    sr_d     = enc ? {bit_in, hist[K-2:1]} : sr_q;
    phase_d  = enc ? ph_next : phase_q;
    rate_d   = sop ? rate_sel : rate_q;
    buf_d    = enc ? {b, keep_a ? a : b} : pop ? {1'b0, buf_q[1]} : buf_q;
    beop_d   = enc ? {last & keep_a & keep_b, last & !(keep_a & keep_b)} : pop ? {1'b0, beop_q[1]} : beop_q;
    pend_d   = enc ? ((keep_a & keep_b) ? 2'd2 : 2'd1) : pend_q - {1'b0, pop};
    state_d  = state_q;
    tail_d   = tail_q;
    if (xfer) begin
      state_d = din_eop ? (TAIL_EN ? TAIL : IDLE) : din_sop ? DATA : state_q;
      tail_d  = '0;
    end
    if (tail_go) begin
      state_d = (tail_q == TW'(K - 2)) ? IDLE : TAIL;
      tail_d  = tail_q + TW'(1);
    end
  end
  // State, history and serializer registers.
  always_ff @(posedge din_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      phase_q   <= '0;
      rate_q    <= '0;
      pend_q    <= '0;
      buf_q     <= '0;
      beop_q    <= '0;
      tail_q    <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      phase_q   <= phase_d;
      rate_q    <= rate_d;
      pend_q    <= pend_d;
      buf_q     <= buf_d;
      beop_q    <= beop_d;
      tail_q    <= tail_d;
      started_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_data_conv_punct_enc.sv
// tb_data_conv_punct_enc: randomized bench against a window-based encode+puncture model
module tb_data_conv_punct_enc;
  localparam int K = 7;
  localparam logic [K-1:0] GA = 7'o133;
  localparam logic [K-1:0] GB = 7'o171;
  logic din_clk = 1'b0;
  logic rst, din, din_vld, din_sop, din_eop, dout_rdy, sel;
  logic [1:0] rate_sel;
  logic rdy_t, dout_t, vld_t, eop_t, rdy_n, dout_n, vld_n, eop_n;
  logic din_rdy, dout, dout_vld, dout_eop;
  int checks = 0, errors = 0;
  bit fr[64];
  int n;
  bit exp_q[$], got_q[$];
  always #5 din_clk = ~din_clk;
  data_conv_punct_enc #(.K(K), .G_A(GA), .G_B(GB), .TAIL_EN(1'b1)) u_t (
    .din_clk(din_clk), .rst(rst), .din(din), .din_vld(din_vld & !sel), .din_sop(din_sop),
    .din_eop(din_eop), .din_rdy(rdy_t), .rate_sel(rate_sel), .dout(dout_t), .dout_vld(vld_t),
    .dout_eop(eop_t), .dout_rdy(dout_rdy));
  data_conv_punct_enc #(.K(K), .G_A(GA), .G_B(GB), .TAIL_EN(1'b0)) u_n (
    .din_clk(din_clk), .rst(rst), .din(din), .din_vld(din_vld & sel), .din_sop(din_sop),
    .din_eop(din_eop), .din_rdy(rdy_n), .rate_sel(rate_sel), .dout(dout_n), .dout_vld(vld_n),
    .dout_eop(eop_n), .dout_rdy(dout_rdy));
  assign din_rdy  = sel ? rdy_n : rdy_t;
  assign dout     = sel ? dout_n : dout_t;
  assign dout_vld = sel ? vld_n : vld_t;
  assign dout_eop = sel ? eop_n : eop_t;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic build_exp(input int rate, input bit tail_en);
    int m, period, p;
    bit a, b, w;
    exp_q.delete();
    m = n + (tail_en ? K - 1 : 0);
    period = rate == 1 ? 2 : rate == 2 ? 3 : 1;
    for (int i = 0; i < m; i++) begin
      a = 0;
      b = 0;
      for (int j = 0; j < K; j++) begin
        w = (i - j >= 0 && i - j < n) ? fr[i-j] : 1'b0;
        a ^= GA[K-1-j] & w;
        b ^= GB[K-1-j] & w;
      end
      p = i % period;
      if (p != 2) exp_q.push_back(a);
      if (p != 1) exp_q.push_back(b);
    end
  endtask
  task automatic run_frame(input bit s, input int rate, input int mode, input int stall_from, input string tag);
    int idx = 0, cyc = 0;
    bit done = 0, held = 0, hold_d = 0, in_stall;
    sel = s;
    got_q.delete();
    build_exp(rate, !s);
    while (!done && cyc < 2000) begin
      @(negedge din_clk);
      cyc++;
      in_stall = mode == 2 && cyc >= stall_from && cyc < stall_from + 10;
      din_vld  = (idx < n) && (mode == 2 || $urandom_range(3) != 0);
      din      = idx < n ? fr[idx] : 1'b0;
      din_sop  = idx == 0;
      din_eop  = idx == n - 1;
      rate_sel = idx == 0 ? 2'(rate) : 2'($urandom_range(3));
      dout_rdy = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(3) != 0) : !in_stall;
      #1;
      if (in_stall && held) begin
        chk({tag, "_vld_hold"}, dout_vld, 1);
        chk({tag, "_dout_hold"}, dout, hold_d);
      end
      if (in_stall && dout_vld) begin
        chk({tag, "_stall_rdy"}, din_rdy, 0);
        if (!held) begin
          held = 1;
          hold_d = dout;
        end
      end
      if (din_vld && din_rdy) idx++;
      if (dout_vld && dout_rdy) begin
        got_q.push_back(dout);
        if (dout_eop) done = 1;
      end
    end
    chk({tag, "_done"}, done, 1);
    if (mode == 2) chk({tag, "_stall_seen"}, held, 1);
    din_vld = 0;
    dout_rdy = 1;
    repeat (3) begin
      @(negedge din_clk);
      #1 chk({tag, "_idle"}, dout_vld, 0);
    end
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk({tag, "_bit"}, got_q[i], exp_q[i]);
  endtask
  task automatic rand_fill(input int len);
    n = len;
    for (int i = 0; i < len; i++) fr[i] = 1'($urandom_range(1));
  endtask
  initial begin
    bit [13:0] imp;
    int lens[3];
    int idx;
    imp = 14'b11011111001011;
    lens[0] = 24; lens[1] = 18; lens[2] = 16;
    sel = 0; din = 0; din_vld = 0; din_sop = 0; din_eop = 0; dout_rdy = 1; rate_sel = 0;
    rst = 1;
    #1;
    chk("rst_rdy", din_rdy, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_dout", dout, 0);
    chk("rst_eop", dout_eop, 0);
    repeat (2) @(negedge din_clk);
    rst = 0;
    #1 chk("rdy_before_edge", din_rdy, 0);
    @(posedge din_clk);
    #1 chk("rdy_after_edge", din_rdy, 1);
    n = 1; fr[0] = 1;
    run_frame(0, 0, 0, -100, "impulse");
    chk("impulse_len14", got_q.size(), 14);
    for (int i = 0; i < 14 && i < got_q.size(); i++) chk("impulse_gold", got_q[i], imp[13-i]);
    for (int r = 0; r < 3; r++) begin
      rand_fill(6);
      run_frame(0, r, 0, -100, "count");
      chk("count_rate", got_q.size(), lens[r]);
    end
    rand_fill(12);
    run_frame(0, 2, 2, 5, "stall");
    rand_fill(4);
    run_frame(0, 1, 1, -100, "latch23");
    rand_fill(5);
    run_frame(0, 2, 1, -100, "latch34");
    n = 4;
    for (int i = 0; i < 4; i++) fr[i] = 1;
    run_frame(1, 0, 1, -100, "notail");
    chk("notail_len8", got_q.size(), 8);
    rand_fill(5);
    run_frame(1, 2, 1, -100, "notail_hist");
    rand_fill(3);
    sel = 0;
    idx = 0;
    for (int c = 0; c < 200 && idx < n; c++) begin
      @(negedge din_clk);
      din_vld = 1; din = fr[idx]; din_sop = idx == 0; din_eop = idx == n - 1; rate_sel = 2'd1; dout_rdy = 1;
      #1 if (din_rdy) idx++;
    end
    chk("rst_eop_sent", idx, n);
    @(negedge din_clk);
    din_vld = 0;
    @(negedge din_clk);
    #1 chk("tail_busy_rdy", din_rdy, 0);
    #1 rst = 1;
    #1;
    chk("async_vld", dout_vld, 0);
    chk("async_dout", dout, 0);
    chk("async_eop", dout_eop, 0);
    chk("async_rdy", din_rdy, 0);
    repeat (2) @(negedge din_clk);
    rst = 0;
    @(posedge din_clk);
    run_frame(0, 1, 0, -100, "post_rst");
    for (int f = 0; f < 8; f++) begin
      rand_fill($urandom_range(1, 10));
      run_frame(1'($urandom_range(1)), $urandom_range(3), 1, -100, "random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
